// File: rtl/freq_multi_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | freq_multi_monitor : sweeps the counter result RAM once per start pulse and |
// |   checks every channel's frequency against its unsigned [lo,hi] limits.    |
// |   Optional macro FREQ_MON_FILTER_EN: fault only after MISS_N bad scans.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module freq_multi_monitor #(
   parameter int NF     = 8,
   parameter int NA     = 3,
   parameter int UW     = 28,
   parameter int RD_LAT = 2
`ifdef FREQ_MON_FILTER_EN
  ,parameter int MISS_N = 3
`endif
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          enable_i,
   input  logic          start_i,
   output logic [NA-1:0] addr_o,
   input  logic [UW-1:0] frequency_i,
   input  logic          lim_we_i,
   input  logic [NA-1:0] lim_addr_i,
   input  logic          lim_hi_i,
   input  logic [UW-1:0] lim_wdata_i,
   input  logic [NF-1:0] fault_clr_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [NF-1:0] fault_o,
   output logic [NF-1:0] in_range_o,
   output logic [15:0]   scan_count_o
);

   localparam int WW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [WW-1:0] C_WRELOAD = WW'(RD_LAT - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [NA-1:0] addr_q, addr_d;
   logic [WW-1:0] wcnt_q, wcnt_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [NF-1:0] fault_q, fault_d;
   logic [NF-1:0] inr_q, inr_d;
   logic [15:0]   scan_q, scan_d;
   logic [UW-1:0] lo_q [NF];
   logic [UW-1:0] hi_q [NF];

   logic          w_ok;
   logic          w_check;
   logic          w_abort;
   logic [NF-1:0] w_set;

   assign w_ok    = (lo_q[addr_q] <= frequency_i) && (frequency_i <= hi_q[addr_q]);
   assign w_check = (state_q == S_CHECK) && enable_i;
   assign w_abort = (state_q != S_IDLE) && !enable_i;

`ifdef FREQ_MON_FILTER_EN
   localparam int MW = $clog2(MISS_N + 1);
   logic [MW-1:0] miss_q [NF];
   logic [MW-1:0] miss_d [NF];

   // Fault fires only on the bad check that brings the counter up to MISS_N.
   always_comb begin
      miss_d = miss_q;
      w_set  = '0;
      if (w_check) begin
         if (w_ok) begin
            miss_d[addr_q] = '0;
         end else begin
            if (miss_q[addr_q] != MW'(MISS_N))
               miss_d[addr_q] = miss_q[addr_q] + MW'(1);
            if (miss_q[addr_q] == MW'(MISS_N - 1))
               w_set[addr_q] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NF; i++) miss_q[i] <= '0;
      end else begin
         miss_q <= miss_d;
      end
   end
`else
   always_comb begin
      w_set = '0;
      if (w_check && !w_ok) w_set[addr_q] = 1'b1;
   end
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wcnt_d  = wcnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      inr_d   = inr_q;
      scan_d  = scan_q;
      if (w_abort) begin
         state_d = S_IDLE;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i && enable_i) begin
                  addr_d  = '0;
                  wcnt_d  = C_WRELOAD;
                  busy_d  = 1'b1;
                  state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               if (wcnt_q == '0) state_d = S_CHECK;
               else              wcnt_d  = wcnt_q - WW'(1);
            end
            S_CHECK: begin
               inr_d[addr_q] = w_ok;
               if (addr_q == NA'(NF - 1)) begin
                  state_d = S_DONE;
               end else begin
                  addr_d  = addr_q + NA'(1);
                  wcnt_d  = C_WRELOAD;
                  state_d = S_WAIT;
               end
            end
            S_DONE: begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               scan_d  = scan_q + 16'd1;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
      // A set in the same cycle as a clear wins.
      fault_d = (fault_q & ~fault_clr_i) | w_set;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wcnt_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fault_q <= '0;
         inr_q   <= '0;
         scan_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wcnt_q  <= wcnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         fault_q <= fault_d;
         inr_q   <= inr_d;
         scan_q  <= scan_d;
      end
   end

   // Limits written in a channel's CHECK cycle take effect from the next check.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NF; i++) begin
            lo_q[i] <= '0;
            hi_q[i] <= '1;
         end
      end else if (lim_we_i) begin
         if (lim_hi_i) hi_q[lim_addr_i] <= lim_wdata_i;
         else          lo_q[lim_addr_i] <= lim_wdata_i;
      end
   end

   assign addr_o       = addr_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign fault_o      = fault_q;
   assign in_range_o   = inr_q;
   assign scan_count_o = scan_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_multi_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_freq_multi_monitor : bench for freq_multi_monitor with a two-stage RAM   |
// |   model, limit vector table and done-driven scoreboard.                    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_freq_multi_monitor;

   localparam int NF = 8;
   localparam int NA = 3;
   localparam int UW = 28;
`ifdef FREQ_MON_FILTER_EN
   localparam int MISS_N = 3;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          enable_i = 1'b1;
   logic          start_i = 1'b0;
   logic [NA-1:0] addr_o;
   logic [UW-1:0] frequency_i;
   logic          lim_we_i = 1'b0;
   logic [NA-1:0] lim_addr_i = '0;
   logic          lim_hi_i = 1'b0;
   logic [UW-1:0] lim_wdata_i = '0;
   logic [NF-1:0] fault_clr_i = '0;
   logic          busy_o;
   logic          done_o;
   logic [NF-1:0] fault_o;
   logic [NF-1:0] in_range_o;
   logic [15:0]   scan_count_o;

   always #5 clk = ~clk;

   freq_multi_monitor dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable_i     (enable_i),
      .start_i      (start_i),
      .addr_o       (addr_o),
      .frequency_i  (frequency_i),
      .lim_we_i     (lim_we_i),
      .lim_addr_i   (lim_addr_i),
      .lim_hi_i     (lim_hi_i),
      .lim_wdata_i  (lim_wdata_i),
      .fault_clr_i  (fault_clr_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .fault_o      (fault_o),
      .in_range_o   (in_range_o),
      .scan_count_o (scan_count_o)
   );

   // Registered RAM read followed by one pipe stage: two cycles of latency.
   logic [UW-1:0] mem [NF];
   logic [UW-1:0] ram_q;
   always @(posedge clk) begin
      ram_q       <= mem[addr_o];
      frequency_i <= ram_q;
   end

   int tests = 0;
   int fails = 0;
   int done_seen = 0;

   typedef struct { logic [7:0] fault; logic [7:0] inr; logic [15:0] scan; } exp_t;
   exp_t sb [$];

   typedef struct {
      int ch; logic [27:0] lo; logic [27:0] hi; logic [27:0] f;
      logic [7:0] clr; logic exp_inr; logic exp_flt;
   } vec_t;
   vec_t vt [9];

   logic [UW-1:0] m_lo [NF];
   logic [UW-1:0] m_hi [NF];
   logic [7:0]    m_fault, m_inr;
   logic [15:0]   m_scan;
   int            m_miss [NF];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && done_o) begin
         done_seen++;
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got done with empty scoreboard expected none");
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_fault", 32'(fault_o), 32'(e.fault));
            chk("sb_in_range", 32'(in_range_o), 32'(e.inr));
            chk("sb_scan_count", 32'(scan_count_o), 32'(e.scan));
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < NF; i++) begin
         m_lo[i] = '0; m_hi[i] = '1; m_miss[i] = 0;
      end
      m_fault = '0; m_inr = '0; m_scan = '0;
   endtask

   task automatic model_sweep(input logic [7:0] clr_mid);
      exp_t e;
      logic ok, setb;
      m_fault = m_fault & ~clr_mid;
      for (int i = 0; i < NF; i++) begin
         ok = (m_lo[i] <= mem[i]) && (mem[i] <= m_hi[i]);
         m_inr[i] = ok;
`ifdef FREQ_MON_FILTER_EN
         setb = !ok && (m_miss[i] == MISS_N - 1);
         if (ok) m_miss[i] = 0;
         else if (m_miss[i] < MISS_N) m_miss[i]++;
`else
         setb = !ok;
`endif
         if (setb) m_fault[i] = 1'b1;
      end
      m_scan++;
      e.fault = m_fault; e.inr = m_inr; e.scan = m_scan;
      sb.push_back(e);
   endtask

   task automatic wr_lim(input int ch, input logic hi, input logic [UW-1:0] v);
      lim_we_i = 1'b1; lim_addr_i = NA'(ch); lim_hi_i = hi; lim_wdata_i = v;
      @(negedge clk);
      lim_we_i = 1'b0;
      if (hi) m_hi[ch] = v; else m_lo[ch] = v;
   endtask

   task automatic clr_fault(input logic [7:0] m);
      fault_clr_i = m;
      @(negedge clk);
      fault_clr_i = '0;
      m_fault = m_fault & ~m;
   endtask

   // Starts one sweep at the next edge k; n counts negedges after edge k.
   task automatic run_sweep(input int clr_n, input logic [7:0] clr_m,
                            input bit extra, input bit chk_addr);
      int done_at;
      bit addr_ok;
      model_sweep(clr_m);
      done_at = -1;
      addr_ok = 1'b1;
      start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
      for (int n = 0; n < 28; n++) begin
         @(negedge clk);
         if (n < 24 && addr_o != NA'(n / 3)) addr_ok = 1'b0;
         if (done_o && done_at < 0) done_at = n;
         fault_clr_i = (n == clr_n - 1) ? clr_m : '0;
         start_i     = extra && (n == 4 || n == 9);
      end
      start_i = 1'b0;
      chk("done_latency", 32'(done_at), 32'd25);
      if (chk_addr) chk("addr_sequence", 32'(addr_ok), 32'd1);
      chk("busy_after_sweep", 32'(busy_o), 32'd0);
   endtask

   initial begin
      vt[0] = '{3, 28'd1000, 28'd2000, 28'd999,  8'h00, 1'b0, 1'b1};
      vt[1] = '{3, 28'd1000, 28'd2000, 28'd1000, 8'h00, 1'b1, 1'b1};
      vt[2] = '{3, 28'd1000, 28'd2000, 28'd2000, 8'h00, 1'b1, 1'b1};
      vt[3] = '{3, 28'd1000, 28'd2000, 28'd2001, 8'h08, 1'b0, 1'b1};
      vt[4] = '{5, 28'd500,  28'd400,  28'd450,  8'h00, 1'b0, 1'b1};
      vt[5] = '{5, 28'd500,  28'd400,  28'd0,    8'h00, 1'b0, 1'b1};
      vt[6] = '{5, 28'd500,  28'd400,  28'hFFFFFFF, 8'h00, 1'b0, 1'b1};
      vt[7] = '{0, 28'd0,    28'd0,    28'd0,    8'h00, 1'b1, 1'b0};
      vt[8] = '{7, 28'hFFFFFFF, 28'hFFFFFFF, 28'hFFFFFFE, 8'h00, 1'b0, 1'b1};

      for (int i = 0; i < NF; i++) mem[i] = 28'd12345;
      model_reset();
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_addr", 32'(addr_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_fault", 32'(fault_o), 32'd0);
      chk("rst_in_range", 32'(in_range_o), 32'd0);
      chk("rst_scan_count", 32'(scan_count_o), 32'd0);

      // Default limits accept everything.
      run_sweep(-10, 8'h00, 1'b0, 1'b1);
      chk("t1_in_range", 32'(in_range_o), 32'hFF);
      chk("t1_fault", 32'(fault_o), 32'h00);
      chk("t1_scan", 32'(scan_count_o), 32'd1);

      for (int v = 0; v < 9; v++) begin
         wr_lim(vt[v].ch, 1'b0, vt[v].lo);
         wr_lim(vt[v].ch, 1'b1, vt[v].hi);
         mem[vt[v].ch] = vt[v].f;
         if (vt[v].clr != 8'h00) clr_fault(vt[v].clr);
         run_sweep(-10, 8'h00, 1'b0, 1'b0);
         chk($sformatf("vec%0d_in_range", v), 32'(in_range_o[vt[v].ch]), 32'(vt[v].exp_inr));
`ifndef FREQ_MON_FILTER_EN
         chk($sformatf("vec%0d_fault", v), 32'(fault_o[vt[v].ch]), 32'(vt[v].exp_flt));
`endif
      end

      // Clear on ch3 in the very cycle of its bad check: set must win.
      clr_fault(8'hFF);
      mem[3] = 28'd999;
      run_sweep(12, 8'h08, 1'b0, 1'b0);
`ifndef FREQ_MON_FILTER_EN
      chk("t3_set_wins", 32'(fault_o[3]), 32'd1);
`endif
      mem[3] = 28'd1500;
      clr_fault(8'h08);
      chk("t3_clear", 32'(fault_o[3]), 32'd0);

      // Restarts during a sweep are ignored.
      begin
         int d0;
         d0 = done_seen;
         run_sweep(-10, 8'h00, 1'b1, 1'b0);
         repeat (20) @(negedge clk);
         chk("t4_single_done", 32'(done_seen - d0), 32'd1);
      end

      // start with enable low is ignored.
      enable_i = 1'b0; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      chk("t4_start_disabled", 32'(busy_o), 32'd0);
      enable_i = 1'b1;

      // Abort before ch3's check: ch3 fault must not be raised.
      begin
         int d0;
         logic [7:0] inr0;
         logic [15:0] s0;
         mem[3] = 28'd999;
         clr_fault(8'h08);
         d0 = done_seen; inr0 = in_range_o; s0 = scan_count_o;
         start_i = 1'b1;
         @(posedge clk);
         #1 start_i = 1'b0;
         for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n == 11) enable_i = 1'b0;
            if (n == 12) chk("t4_abort_busy", 32'(busy_o), 32'd0);
         end
         enable_i = 1'b1;
         chk("t4_abort_no_done", 32'(done_seen - d0), 32'd0);
         chk("t4_abort_fault", 32'(fault_o), 32'(m_fault));
         chk("t4_abort_in_range", 32'(in_range_o), 32'(inr0));
         chk("t4_abort_scan", 32'(scan_count_o), 32'(s0));
      end

      // Asynchronous reset mid-sweep restores everything, limits included.
      start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
      repeat (8) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_busy", 32'(busy_o), 32'd0);
      chk("t5_rst_addr", 32'(addr_o), 32'd0);
      chk("t5_rst_fault", 32'(fault_o), 32'd0);
      chk("t5_rst_in_range", 32'(in_range_o), 32'd0);
      chk("t5_rst_scan", 32'(scan_count_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      mem[5] = 28'd450; mem[7] = 28'hFFFFFFE;
      @(negedge clk);
      run_sweep(-10, 8'h00, 1'b0, 1'b0);
      chk("t5_limits_reset_inr", 32'(in_range_o), 32'hFF);
      chk("t5_limits_reset_fault", 32'(fault_o), 32'h00);
      chk("t5_scan_after_reset", 32'(scan_count_o), 32'd1);

      // ch1 pattern bad,bad,good,bad,bad,bad.
      begin
         logic [5:0] bad_seq;
         logic [5:0] exp_flt;
         bad_seq = 6'b111011;
`ifdef FREQ_MON_FILTER_EN
         exp_flt = 6'b100000;
`else
         exp_flt = 6'b111111;
`endif
         wr_lim(1, 1'b0, 28'd100);
         wr_lim(1, 1'b1, 28'd200);
         for (int s = 0; s < 6; s++) begin
            mem[1] = bad_seq[s] ? 28'd50 : 28'd150;
            run_sweep(-10, 8'h00, 1'b0, 1'b0);
            chk($sformatf("t6_scan%0d_fault1", s), 32'(fault_o[1]), 32'(exp_flt[s]));
            chk($sformatf("t6_scan%0d_inr1", s), 32'(in_range_o[1]), 32'(!bad_seq[s]));
         end
      end

      repeat (5) @(negedge clk);
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
